exe_seq: RTL and testbench

//  Parametrised execution sequencer for the USM CPU; successor of the single-cycle run/stop FSM.

---
 rtl/exe_seq.sv | 194 +++++++++++++++++++
 tb/tb_exe_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_seq.sv
// exe_seq: fetch/execute sequencer for the USM CPU with multi-cycle execute, single step,
// fetch timeout fault and a saturating retired-instruction counter. Optional limit: EXE_SEQ_LIMIT_EN.
module exe_seq #(
   parameter int EXEC_CYCLES   = 1,
   parameter int FETCH_TIMEOUT = 255,
   parameter int TO_W          = 8,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step,
   input  logic             run,
   input  logic             clr,
`ifdef EXE_SEQ_LIMIT_EN
   input  logic [CNT_W-1:0] instr_limit,
`endif
   output logic             instr_query,
   output logic             cpu_run,
   output logic             busy,
   output logic             fault,
   output logic             limit_hit,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int               EC_W      = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [EC_W-1:0]  EXEC_LAST = EC_W'(EXEC_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(FETCH_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [TO_W-1:0]  to_cnt_r;
   logic [EC_W-1:0]  exec_cnt_r;
   logic             stop_pend_r;
   logic             step_mode_r;
   logic [CNT_W-1:0] instr_cnt_r;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             exec_done_s;
   logic             limit_match_s;
   logic             instr_query_r;
   logic             cpu_run_r;
   logic             busy_r;
   logic             fault_r;

   assign exec_done_s = (state_r == EXEC) && (exec_cnt_r == EXEC_LAST);

   // Saturating successor of the retired-instruction count
   always_comb begin
      cnt_inc_s = instr_cnt_r;
      if (instr_cnt_r == CNT_MAX) begin
         cnt_inc_s = instr_cnt_r;
      end else begin
         cnt_inc_s = instr_cnt_r + CNT_W'(1);
      end
   end

`ifdef EXE_SEQ_LIMIT_EN
   logic limit_hit_r;

   assign limit_match_s = (instr_limit != {CNT_W{1'b0}}) && (cnt_inc_s == instr_limit);
   assign limit_hit     = limit_hit_r;

   // One-cycle pulse after the completion that reaches the programmed limit
   always_ff @(posedge clk) begin
      if (reset) begin
         limit_hit_r <= 1'b0;
      end else begin
         limit_hit_r <= exec_done_s && limit_match_s;
      end
   end
`else
   assign limit_match_s = 1'b0;
   assign limit_hit     = 1'b0;
`endif

   // Next-state selection; an abort in FETCH outranks the timeout
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start || step) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FETCH: begin
            if (run) begin
               state_nxt_s = EXEC;
            end else if (start) begin
               state_nxt_s = IDLE;
            end else if (to_cnt_r == TO_LAST) begin
               state_nxt_s = FAULT;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         EXEC: begin
            if (!exec_done_s) begin
               state_nxt_s = EXEC;
            end else if (stop_pend_r || step_mode_r || start || limit_match_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FETCH;
            end
         end
         FAULT: begin
            if (clr) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FAULT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, timers, mode flags, counter and Moore outputs registered from the next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         to_cnt_r      <= {TO_W{1'b0}};
         exec_cnt_r    <= {EC_W{1'b0}};
         stop_pend_r   <= 1'b0;
         step_mode_r   <= 1'b0;
         instr_cnt_r   <= {CNT_W{1'b0}};
         instr_query_r <= 1'b0;
         cpu_run_r     <= 1'b0;
         busy_r        <= 1'b0;
         fault_r       <= 1'b0;
      end else begin
         state_r <= state_nxt_s;

         if ((state_r == FETCH) && (state_nxt_s == FETCH)) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end else begin
            to_cnt_r <= {TO_W{1'b0}};
         end

         if ((state_r == EXEC) && (state_nxt_s == EXEC)) begin
            exec_cnt_r <= exec_cnt_r + EC_W'(1);
         end else begin
            exec_cnt_r <= {EC_W{1'b0}};
         end

         if (state_nxt_s == IDLE) begin
            stop_pend_r <= 1'b0;
         end else if (start && (((state_r == FETCH) && run) || (state_r == EXEC))) begin
            stop_pend_r <= 1'b1;
         end else begin
            stop_pend_r <= stop_pend_r;
         end

         // Leaving IDLE: start wins over step, so single-step only when start is low
         if (state_nxt_s == IDLE) begin
            step_mode_r <= 1'b0;
         end else if (state_r == IDLE) begin
            step_mode_r <= step && !start;
         end else begin
            step_mode_r <= step_mode_r;
         end

         if (clr) begin
            instr_cnt_r <= {CNT_W{1'b0}};
         end else if (exec_done_s) begin
            instr_cnt_r <= cnt_inc_s;
         end else begin
            instr_cnt_r <= instr_cnt_r;
         end

         instr_query_r <= (state_nxt_s == FETCH);
         cpu_run_r     <= (state_nxt_s == EXEC);
         busy_r        <= (state_nxt_s != IDLE);
         fault_r       <= (state_nxt_s == FAULT);
      end
   end

   assign instr_query = instr_query_r;
   assign cpu_run     = cpu_run_r;
   assign busy        = busy_r;
   assign fault       = fault_r;
   assign instr_cnt   = instr_cnt_r;

endmodule

// File: tb/tb_exe_seq.sv
// Bench for exe_seq: two instances (EXEC_CYCLES=1 / EXEC_CYCLES=3, short timeout, 3-bit counter)
// share directed stimulus; a phase-level model is compared every cycle, plus literal spot checks.
module tb_exe_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        step = 1'b0;
   logic        run = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] instr_limit = 32'd0;

   logic        a_iq, a_cr, a_busy, a_fault, a_hit;
   logic [31:0] a_cnt;
   logic        b_iq, b_cr, b_busy, b_fault, b_hit;
   logic [2:0]  b_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   exe_seq #(.EXEC_CYCLES(1), .FETCH_TIMEOUT(255), .TO_W(8), .CNT_W(32)) dut_a (
      .clk(clk), .reset(reset), .start(start), .step(step), .run(run), .clr(clr),
`ifdef EXE_SEQ_LIMIT_EN
      .instr_limit(instr_limit),
`endif
      .instr_query(a_iq), .cpu_run(a_cr), .busy(a_busy), .fault(a_fault),
      .limit_hit(a_hit), .instr_cnt(a_cnt)
   );

   exe_seq #(.EXEC_CYCLES(3), .FETCH_TIMEOUT(4), .TO_W(3), .CNT_W(3)) dut_b (
      .clk(clk), .reset(reset), .start(start), .step(step), .run(run), .clr(clr),
`ifdef EXE_SEQ_LIMIT_EN
      .instr_limit(instr_limit[2:0]),
`endif
      .instr_query(b_iq), .cpu_run(b_cr), .busy(b_busy), .fault(b_fault),
      .limit_hit(b_hit), .instr_cnt(b_cnt)
   );

   // ph: 0 idle, 1 fetching, 2 executing, 3 faulted; left = execute cycles still owed
   typedef struct {
      int     ph;
      int     age;
      int     left;
      bit     stop;
      bit     single;
      longint cnt;
      bit     hit;
   } mdl_t;

   mdl_t m [2];

   function automatic longint lim_of(input int i);
`ifdef EXE_SEQ_LIMIT_EN
      return (i == 0) ? longint'(instr_limit) : longint'(instr_limit & 32'd7);
`else
      return (i == 0) ? 64'd0 : 64'd0;
`endif
   endfunction

   function automatic mdl_t next_m(input mdl_t c, input int i, input logic rst, input logic st,
                                   input logic sp, input logic rn, input logic cl, input longint lim);
      mdl_t   n;
      longint inc;
      longint maxc;
      bit     done;
      int     ec;
      int     ft;
      ec   = (i == 0) ? 1 : 3;
      ft   = (i == 0) ? 255 : 4;
      maxc = (i == 0) ? 64'hFFFF_FFFF : 64'd7;
      n = c;
      n.hit = 1'b0;
      done = 1'b0;
      inc = c.cnt;
      if (rst) begin
         n.ph = 0; n.age = 0; n.left = 0; n.stop = 0; n.single = 0; n.cnt = 0; n.hit = 0;
         return n;
      end
      case (c.ph)
         0: begin
            if (st) begin
               n.ph = 1; n.age = 0; n.single = 1'b0;
            end else if (sp) begin
               n.ph = 1; n.age = 0; n.single = 1'b1;
            end
         end
         1: begin
            if (rn) begin
               n.ph = 2; n.left = ec;
               if (st) n.stop = 1'b1;
            end else if (st) begin
               n.ph = 0;
            end else if (c.age == ft - 1) begin
               n.ph = 3;
            end else begin
               n.age = c.age + 1;
            end
         end
         2: begin
            if (st) n.stop = 1'b1;
            n.left = c.left - 1;
            if (n.left == 0) begin
               done = 1'b1;
               inc = (c.cnt == maxc) ? c.cnt : c.cnt + 1;
               n.hit = (lim != 0) && (inc == lim);
               n.ph = (n.stop || c.single || n.hit) ? 0 : 1;
               n.age = 0;
            end
         end
         default: begin
            if (cl) n.ph = 0;
         end
      endcase
      if (cl) n.cnt = 0;
      else if (done) n.cnt = inc;
      if (n.ph == 0) begin
         n.stop = 1'b0;
         n.single = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m[0] <= next_m(m[0], 0, reset, start, step, run, clr, lim_of(0));
      m[1] <= next_m(m[1], 1, reset, start, step, run, clr, lim_of(1));
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string p, input mdl_t e, input logic iq, input logic cr, input logic bz,
                      input logic ft, input logic [63:0] cnt, input logic hit);
      check({p, ".instr_query"}, {63'd0, iq},  {63'd0, (e.ph == 1)});
      check({p, ".cpu_run"},     {63'd0, cr},  {63'd0, (e.ph == 2)});
      check({p, ".busy"},        {63'd0, bz},  {63'd0, (e.ph != 0)});
      check({p, ".fault"},       {63'd0, ft},  {63'd0, (e.ph == 3)});
      check({p, ".instr_cnt"},   cnt,          e.cnt);
      check({p, ".limit_hit"},   {63'd0, hit}, {63'd0, e.hit});
   endtask

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("a", m[0], a_iq, a_cr, a_busy, a_fault, {32'd0, a_cnt}, a_hit);
         cmp("b", m[1], b_iq, b_cr, b_busy, b_fault, {61'd0, b_cnt}, b_hit);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((a_busy || b_busy) && k < budget) begin
         cyc();
         k++;
      end
      check("wait_idle", {62'd0, a_busy, b_busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (3) cyc();
      check("rst_a_busy", {63'd0, a_busy}, 64'd0);
      check("rst_a_cnt",  {32'd0, a_cnt},  64'd0);
      check("rst_b_iq",   {63'd0, b_iq},   64'd0);
      check("rst_b_fault", {63'd0, b_fault}, 64'd0);
      reset = 1'b0;
      chk_en = 1'b1;
      cyc();

      // free run with run held high; A alternates fetch/execute every cycle
      run = 1'b1;
      pulse_start();
      check("t1_iq0", {63'd0, a_iq}, 64'd1);
      check("t1_cr0", {63'd0, a_cr}, 64'd0);
      cyc();
      check("t1_iq1", {63'd0, a_iq}, 64'd0);
      check("t1_cr1", {63'd0, a_cr}, 64'd1);
      cyc();
      check("t1_iq2", {63'd0, a_iq}, 64'd1);
      check("t1_cnt1", {32'd0, a_cnt}, 64'd1);
      repeat (4) cyc();
      check("t1_cnt3", {32'd0, a_cnt}, 64'd3);
      pulse_start();
      cyc();
      check("t1_a_idle", {63'd0, a_busy}, 64'd0);
      check("t1_b_idle", {63'd0, b_busy}, 64'd0);
      check("t1_a_cnt4", {32'd0, a_cnt}, 64'd4);
      check("t1_b_cnt2", {61'd0, b_cnt}, 64'd2);
      pulse_clr();
      check("clr_a", {32'd0, a_cnt}, 64'd0);

      // single step: B holds cpu_run for exactly three cycles
      step = 1'b1;
      cyc();
      step = 1'b0;
      check("t2_iq", {63'd0, b_iq}, 64'd1);
      cyc();
      check("t2_cr1", {63'd0, b_cr}, 64'd1);
      cyc();
      check("t2_cr2", {63'd0, b_cr}, 64'd1);
      check("t2_a_idle", {63'd0, a_busy}, 64'd0);
      check("t2_a_cnt", {32'd0, a_cnt}, 64'd1);
      cyc();
      check("t2_cr3", {63'd0, b_cr}, 64'd1);
      cyc();
      check("t2_cr_off", {63'd0, b_cr}, 64'd0);
      check("t2_busy", {63'd0, b_busy}, 64'd0);
      check("t2_cnt", {61'd0, b_cnt}, 64'd1);
      cyc();
      check("t2_no_fetch", {63'd0, b_iq}, 64'd0);
      pulse_clr();

      // stop requested during B's second execute cycle
      pulse_start();
      cyc();
      cyc();
      pulse_start();
      check("t3_cr_hold", {63'd0, b_cr}, 64'd1);
      cyc();
      check("t3_b_idle", {63'd0, b_busy}, 64'd0);
      check("t3_b_cnt", {61'd0, b_cnt}, 64'd1);
      check("t3_a_cnt", {32'd0, a_cnt}, 64'd2);
      repeat (3) cyc();
      check("t3_no_fetch", {63'd0, b_iq}, 64'd0);

      // fetch timeout on B (4 cycles), abort on A, start/step ignored in fault
      run = 1'b0;
      pulse_start();
      repeat (3) cyc();
      check("t4_pre_fault", {63'd0, b_fault}, 64'd0);
      cyc();
      check("t4_fault", {63'd0, b_fault}, 64'd1);
      check("t4_iq", {63'd0, b_iq}, 64'd0);
      start = 1'b1;
      step = 1'b1;
      cyc();
      start = 1'b0;
      step = 1'b0;
      check("t4_hold", {63'd0, b_fault}, 64'd1);
      check("t4_abort", {63'd0, a_busy}, 64'd0);
      pulse_clr();
      check("t4_clr", {63'd0, b_fault}, 64'd0);
      check("t4_idle", {63'd0, b_busy}, 64'd0);
      check("t4_cnt", {61'd0, b_cnt}, 64'd0);

      // clr beats a simultaneous completion; start+step together means free run
      run = 1'b1;
      pulse_start();
      cyc();
      pulse_clr();
      check("t5_clr_wins", {32'd0, a_cnt}, 64'd0);
      check("t5_running", {63'd0, a_iq}, 64'd1);
      cyc();
      cyc();
      check("t5_cnt1", {32'd0, a_cnt}, 64'd1);
      pulse_start();
      wait_idle(20);
      start = 1'b1;
      step = 1'b1;
      cyc();
      start = 1'b0;
      step = 1'b0;
      cyc();
      cyc();
      check("t5_free_iq", {63'd0, a_iq}, 64'd1);
      check("t5_free_busy", {63'd0, a_busy}, 64'd1);
      pulse_start();
      wait_idle(20);

      // saturation of B's 3-bit counter
      pulse_clr();
      pulse_start();
      repeat (40) cyc();
      check("sat_run", {61'd0, b_cnt}, 64'd7);
      pulse_start();
      wait_idle(20);
      check("sat_hold", {61'd0, b_cnt}, 64'd7);

`ifdef EXE_SEQ_LIMIT_EN
      pulse_clr();
      instr_limit = 32'd2;
      pulse_start();
      repeat (4) cyc();
      check("t6_hit", {63'd0, a_hit}, 64'd1);
      check("t6_idle", {63'd0, a_busy}, 64'd0);
      check("t6_cnt", {32'd0, a_cnt}, 64'd2);
      cyc();
      check("t6_pulse", {63'd0, a_hit}, 64'd0);
      wait_idle(20);
      check("t6_b_cnt", {61'd0, b_cnt}, 64'd2);
      instr_limit = 32'd0;
      cyc();
`endif

      // reset in the middle of an instruction
      pulse_start();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("mid_rst_busy", {63'd0, a_busy}, 64'd0);
      check("mid_rst_cr", {63'd0, b_cr}, 64'd0);
      check("mid_rst_cnt", {32'd0, a_cnt}, 64'd0);
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
